// File: rtl/rv32imf_prefetch_pkg.sv
// rv32imf_prefetch_pkg: shared types and constants for the instruction prefetch queue
package rv32imf_prefetch_pkg;
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] addr;
   } fetch_entry_t;
   typedef enum logic {PFQ_IDLE, PFQ_ISSUE} pfq_state_e;
   localparam logic [31:0] PFQ_WORD_INC = 32'd4;
endpackage

// File: rtl/rv32imf_prefetch_fifo.sv
// rv32imf_prefetch_fifo: flushable circular buffer of fetch entries with simultaneous push/pop
module rv32imf_prefetch_fifo
   import rv32imf_prefetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush_i,
   input  logic                            push_i,
   input  logic                            pop_i,
   input  logic [$bits(fetch_entry_t)-1:0] data_i,
   output logic [$bits(fetch_entry_t)-1:0] data_o,
   output logic [$clog2(DEPTH):0]          cnt_o,
   output logic                            empty_o,
   output logic                            full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;
   assign empty_o = cnt_q == '0;
   assign full_o  = cnt_q == CW'(DEPTH);
   assign cnt_o   = cnt_q;
   assign data_o  = mem_q[rd_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   always_comb begin
      wr_d  = flush_i ? '0 : wr_q + AW'(do_push);
      rd_d  = flush_i ? '0 : rd_q + AW'(do_pop);
      cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   always_ff @(posedge clk)
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
   assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o && !pop_i && !flush_i));
endmodule

// File: rtl/rv32imf_prefetch_queue.sv
// rv32imf_prefetch_queue: OBI instruction prefetcher with in-order tags, branch discard and error stall
module rv32imf_prefetch_queue
   import rv32imf_prefetch_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter bit ERR_STALL       = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   input  logic        fetch_ready_i,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_rdata_o,
   output logic [31:0] fetch_addr_o,
   output logic        fetch_err_o,
   output logic        instr_req_o,
   input  logic        instr_gnt_i,
   output logic [31:0] instr_addr_o,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_rvalid_i,
   input  logic        instr_err_i,
   output logic        busy_o
);
   localparam int QW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int DW = OW + 1;
   pfq_state_e    state_q, state_d;
   logic [31:0]   addr_q, addr_d, next_addr_q, next_addr_d;
   logic [OW-1:0] out_cnt_q, out_cnt_d;
   logic [DW-1:0] discard_q, discard_d;
   logic [QW-1:0] q_cnt, q_cnt_d, tag_cnt;
   logic          stale_q, stale_d, err_halt_q, err_halt_d;
   logic          gnt, live_rv, credit, q_push, q_pop, q_empty, q_full;
   logic          tag_push, tag_empty, tag_full;
   fetch_entry_t  q_head, tag_head, bus_entry, shown;
   logic          unused_sink;
   assign instr_req_o   = state_q == PFQ_ISSUE;
   assign instr_addr_o  = addr_q;
   assign busy_o        = out_cnt_q != '0 || instr_req_o;
   assign gnt           = instr_req_o && instr_gnt_i;
   assign live_rv       = instr_rvalid_i && discard_q == '0 && !branch_i;
   assign fetch_valid_o = !branch_i && (!q_empty || live_rv);
   assign q_push        = live_rv && !(q_empty && fetch_ready_i);
   assign q_pop         = fetch_valid_o && fetch_ready_i && !q_empty;
   assign tag_push      = gnt && !stale_q && !branch_i;
   assign bus_entry     = '{rdata: instr_rdata_i, err: instr_err_i, addr: tag_head.addr};
   assign shown         = q_empty ? bus_entry : q_head;
   assign fetch_rdata_o = fetch_valid_o ? shown.rdata : '0;
   assign fetch_addr_o  = fetch_valid_o ? shown.addr : '0;
   assign fetch_err_o   = fetch_valid_o && shown.err;
   assign unused_sink   = ^{q_full, tag_cnt, tag_empty, tag_full, tag_head.rdata, tag_head.err};
   // Credit looks at post-cycle counts so a request granted now is already accounted for.
   always_comb begin
      out_cnt_d   = out_cnt_q + OW'(gnt) - OW'(instr_rvalid_i);
      q_cnt_d     = branch_i ? '0 : q_cnt + QW'(q_push) - QW'(q_pop);
      err_halt_d  = branch_i ? 1'b0 : (ERR_STALL && live_rv && instr_err_i) ? 1'b1 : err_halt_q;
      next_addr_d = branch_i ? {branch_addr_i[31:2], 2'b00}
                  : (gnt && !stale_q) ? next_addr_q + PFQ_WORD_INC : next_addr_q;
      credit      = req_i && !err_halt_d && int'(out_cnt_d) < MAX_OUTSTANDING
                    && int'(out_cnt_d) + int'(q_cnt_d) < DEPTH;
      discard_d   = branch_i ? DW'(out_cnt_d) + DW'(instr_req_o && !gnt)
                  : (instr_rvalid_i && discard_q != '0) ? discard_q - 1'b1 : discard_q;
      stale_d     = gnt ? 1'b0 : (branch_i && instr_req_o) ? 1'b1 : stale_q;
      state_d     = state_q;
      addr_d      = addr_q;
      if (state_q == PFQ_IDLE || gnt) begin
         state_d = credit ? PFQ_ISSUE : PFQ_IDLE;
         addr_d  = credit ? next_addr_d : addr_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= PFQ_IDLE;
         addr_q      <= '0;
         next_addr_q <= '0;
         out_cnt_q   <= '0;
         discard_q   <= '0;
         stale_q     <= 1'b0;
         err_halt_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         next_addr_q <= next_addr_d;
         out_cnt_q   <= out_cnt_d;
         discard_q   <= discard_d;
         stale_q     <= stale_d;
         err_halt_q  <= err_halt_d;
      end
   rv32imf_prefetch_fifo #(.DEPTH(DEPTH)) u_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (branch_i),
      .push_i  (q_push),
      .pop_i   (q_pop),
      .data_i  (bus_entry),
      .data_o  (q_head),
      .cnt_o   (q_cnt),
      .empty_o (q_empty),
      .full_o  (q_full)
   );
   rv32imf_prefetch_fifo #(.DEPTH(DEPTH)) u_tag (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (branch_i),
      .push_i  (tag_push),
      .pop_i   (live_rv),
      .data_i  ({32'b0, 1'b0, addr_q}),
      .data_o  (tag_head),
      .cnt_o   (tag_cnt),
      .empty_o (tag_empty),
      .full_o  (tag_full)
   );
endmodule

// File: tb/tb_rv32imf_prefetch_queue.sv
// tb_rv32imf_prefetch_queue: scoreboard bench with OBI slave model and sequential-fetch reference
module tb_rv32imf_prefetch_queue;
   localparam int MAXO = 2;
   localparam int WIN  = 1024;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req_i = 1'b0, branch_i = 1'b0, fetch_ready_i = 1'b0;
   logic [31:0] branch_addr_i = '0;
   logic fetch_valid_o, fetch_err_o, instr_req_o, busy_o;
   logic [31:0] fetch_rdata_o, fetch_addr_o, instr_addr_o;
   logic instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
   logic [31:0] instr_rdata_i = '0;
   typedef struct { logic [31:0] addr; logic [31:0] data; logic err; } exp_t;
   typedef struct { logic [31:0] addr; int rdy; } bus_t;
   exp_t exp_q[$];
   bus_t bus_q[$];
   int checks = 0, passes = 0, delivered = 0, cyc = 0;
   int gnt_pct = 100, rv_pct = 100, lat_min = 0, lat_extra = 0;
   int win_grants = 0, post_err = 0;
   logic err_active = 1'b0, prev_pending = 1'b0;
   logic [31:0] err_addr = 32'hFFFF_FFFF, win_lo = '0, prev_addr = '0, held;

   rv32imf_prefetch_queue dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
      .fetch_ready_i(fetch_ready_i), .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o),
      .fetch_addr_o(fetch_addr_o), .fetch_err_o(fetch_err_o), .instr_req_o(instr_req_o),
      .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i),
      .instr_rvalid_i(instr_rvalid_i), .instr_err_i(instr_err_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endfunction

   function automatic void fail(input string name);
      checks++;
      $display("FAIL %s: timed out waiting", name);
   endfunction

   // Reference: after a redirect the IF stage must see consecutive words from the aligned target.
   task automatic do_branch(input logic [31:0] a);
      logic [31:0] base;
      base = {a[31:2], 2'b00};
      branch_i = 1'b1;
      branch_addr_i = {a[31:1], 1'b0};
      exp_q.delete();
      for (int k = 0; k < WIN; k++)
         exp_q.push_back('{addr: base + 32'(4 * k), data: mem(base + 32'(4 * k)), err: base + 32'(4 * k) == err_addr});
      err_active = 1'b0;
      post_err = 0;
      @(negedge clk);
      branch_i = 1'b0;
   endtask

   task automatic wait_delivered(input int n, input int budget, input string name);
      int target;
      target = delivered + n;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #3;
         if (delivered >= target) return;
      end
      fail(name);
   endtask

   task automatic wait_idle();
      req_i = 1'b0;
      fetch_ready_i = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (!busy_o && !fetch_valid_o) return;
      end
      fail("wait_idle");
   endtask

   // OBI slave: random grant, in-order responses, garbage on rdata/err when not valid
   always @(negedge clk) begin
      if (!rst_n) begin
         bus_q.delete();
         instr_gnt_i = 1'b0;
         instr_rvalid_i = 1'b0;
      end else begin
         instr_gnt_i = instr_req_o && ($urandom_range(99) < gnt_pct);
         instr_rvalid_i = bus_q.size() > 0 && bus_q[0].rdy <= cyc && ($urandom_range(99) < rv_pct);
         if (instr_rvalid_i) begin
            instr_rdata_i = mem(bus_q[0].addr);
            instr_err_i = bus_q[0].addr == err_addr;
            void'(bus_q.pop_front());
         end else begin
            instr_rdata_i = $urandom;
            instr_err_i = 1'($urandom_range(1));
         end
         if (instr_gnt_i) begin
            bus_q.push_back('{addr: instr_addr_o, rdy: cyc + 1 + lat_min + int'($urandom_range(lat_extra))});
            if (instr_addr_o - win_lo < 32'h100) win_grants++;
            check("outstanding_limit", 32'(bus_q.size() <= MAXO), 32'd1);
         end
      end
   end

   // Monitor: pops the scoreboard on every accepted word and watches OBI stability
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst_n) begin
         if (branch_i) check("valid_on_branch", 32'(fetch_valid_o), 32'd0);
         if (fetch_valid_o && fetch_ready_i) begin
            delivered++;
            if (exp_q.size() == 0) fail("unexpected_word");
            else begin
               e = exp_q.pop_front();
               check("fetch_addr", fetch_addr_o, e.addr);
               check("fetch_rdata", fetch_rdata_o, e.data);
               check("fetch_err", 32'(fetch_err_o), 32'(e.err));
               if (err_active) begin
                  post_err++;
                  check("words_after_err", 32'(post_err <= MAXO), 32'd1);
               end
               if (e.err) err_active = 1'b1;
            end
         end
         if (prev_pending) begin
            check("req_hold", 32'(instr_req_o), 32'd1);
            check("addr_hold", instr_addr_o, prev_addr);
         end
         if (instr_req_o) check("addr_align", 32'(instr_addr_o[1:0]), 32'd0);
         prev_pending = instr_req_o && !instr_gnt_i;
         prev_addr = instr_addr_o;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] tgt;
      repeat (3) @(negedge clk);
      #3;
      check("rst_fetch_valid", 32'(fetch_valid_o), 32'd0);
      check("rst_instr_req", 32'(instr_req_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_instr_addr", instr_addr_o, 32'd0);
      check("rst_fetch_addr", fetch_addr_o, 32'd0);
      check("rst_fetch_rdata", fetch_rdata_o, 32'd0);
      check("rst_fetch_err", 32'(fetch_err_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // sequential fetch with single-cycle bus, every word falls through
      @(negedge clk); #1;
      req_i = 1'b1;
      fetch_ready_i = 1'b1;
      do_branch(32'h100);
      wait_delivered(3, 30, "seq_0x100");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #3;
         if (instr_rvalid_i) begin
            check("fallthrough_valid", 32'(fetch_valid_o), 32'd1);
            check("fallthrough_qcnt", 32'(dut.u_q.cnt_o), 32'd0);
         end
      end
      // IF stalled: fetching stops with the queue exactly full
      @(negedge clk); #1;
      fetch_ready_i = 1'b0;
      win_lo = 32'h400;
      win_grants = 0;
      do_branch(32'h400);
      repeat (20) @(negedge clk);
      #3;
      check("full_grants", 32'(win_grants), 32'd4);
      check("full_req_low", 32'(instr_req_o), 32'd0);
      check("full_busy", 32'(busy_o), 32'd0);
      check("full_qcnt", 32'(dut.u_q.cnt_o), 32'd4);
      check("full_valid", 32'(fetch_valid_o), 32'd1);
      check("full_head_addr", fetch_addr_o, 32'h400);
      @(negedge clk); #1;
      fetch_ready_i = 1'b1;
      wait_delivered(6, 40, "drain_0x400");
      // two outstanding responses become stale on redirect
      @(negedge clk); #1;
      lat_min = 4;
      do_branch(32'h180);
      for (int i = 0; i <= 20; i++) begin
         if (i == 20) fail("two_outstanding");
         @(negedge clk); #1;
         if (bus_q.size() == 2) break;
      end
      do_branch(32'h200);
      wait_delivered(3, 60, "after_stale_0x200");
      lat_min = 0;
      // grant withheld, redirect while the request waits
      wait_idle();
      gnt_pct = 0;
      req_i = 1'b1;
      do_branch(32'h500);
      for (int i = 0; i <= 6; i++) begin
         if (i == 6) fail("req_0x500");
         @(negedge clk); #1;
         if (instr_req_o) break;
      end
      held = instr_addr_o;
      check("pending_addr", held, 32'h500);
      do_branch(32'h600);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #3;
         check("gnt_wait_req", 32'(instr_req_o), 32'd1);
         check("gnt_wait_addr", instr_addr_o, 32'h500);
      end
      @(negedge clk); #1;
      gnt_pct = 100;
      wait_delivered(3, 40, "after_gnt_wait_0x600");
      // bus error stalls issue until the next redirect
      @(negedge clk); #1;
      err_addr = 32'h304;
      do_branch(32'h300);
      for (int i = 0; i <= 30; i++) begin
         if (i == 30) fail("err_word");
         @(negedge clk); #3;
         if (err_active) break;
      end
      repeat (10) @(negedge clk);
      #3;
      check("err_req_low", 32'(instr_req_o), 32'd0);
      check("err_busy", 32'(busy_o), 32'd0);
      check("err_valid_low", 32'(fetch_valid_o), 32'd0);
      @(negedge clk); #1;
      do_branch(32'h700);
      for (int i = 0; i <= 5; i++) begin
         if (i == 5) fail("resume_req");
         @(negedge clk); #1;
         if (instr_req_o) break;
      end
      wait_delivered(3, 30, "resume_0x700");
      err_addr = 32'hFFFF_FFFF;
      // redirect in the same cycle as a response
      for (int i = 0; i <= 20; i++) begin
         if (i == 20) fail("rvalid_for_branch");
         @(negedge clk); #1;
         if (instr_rvalid_i) break;
      end
      do_branch(32'h800);
      wait_delivered(3, 30, "after_branch_rv_0x800");
      // address wrap, unaligned bit1 in target
      @(negedge clk); #1;
      do_branch(32'hFFFF_FFFA);
      wait_delivered(3, 30, "wrap");
      // randomized traffic
      gnt_pct = 70;
      rv_pct = 70;
      lat_extra = 2;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk); #1;
         req_i = $urandom_range(9) != 0;
         fetch_ready_i = $urandom_range(9) < 7;
         if ($urandom_range(39) == 0) begin
            tgt = $urandom_range(3) == 0 ? 32'hFFFF_FFE0 + 32'($urandom_range(15)) : $urandom;
            err_addr = $urandom_range(3) == 0 ? {tgt[31:2], 2'b00} + 32'(4 * $urandom_range(5)) : 32'hFFFF_FFFF;
            do_branch(tgt);
         end
      end
      check("random_progress", 32'(delivered > 150), 32'd1);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
